sbox_sched: RTL and testbench

Time-multiplexed SubBytes engine that shares one bank of four AES S-box lanes between two requesters: the round datapath (128-bit state, processed in four 32-bit beats) and the key schedule (one 32-bit SubWord). It sits between the round controller and key expansion and replaces per-requester S-box copies. A request/acknowledge front end, an arbiter and a small FSM sequence the shared lanes.

---
 rtl/sbox_sched_pkg.sv | 27 ++
 rtl/sbox.sv | 12 +
 rtl/sbox_sched_word.sv | 16 +
 rtl/sbox_sched.sv | 135 +++++++++++++
 tb/tb_sbox_sched.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sbox_sched_pkg.sv
// Shared types and constants for the time-multiplexed SubBytes engine.
// Byte order throughout: byte 0 is the most significant byte of a word.
package sbox_sched_pkg;

  typedef enum logic [1:0] {IDLE, ST_RUN, KS_RUN} state_e;

  localparam int SBOX_LANES = 4;
  localparam int ST_BEATS   = 4;
  localparam int BYTE_W     = 8;

  // AES forward S-box, entry 0x00 in the top byte
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [BYTE_W-1:0] lane_byte(input logic [31:0] w, input int i);
    return w[31-BYTE_W*i -: BYTE_W];
  endfunction

endpackage

// File: rtl/sbox.sv
// Single AES forward S-box lane, combinational table lookup.
module sbox
  import sbox_sched_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  // entry x lives at bit offset (255-x)*8, and ~x == 255-x for 8 bits
  assign y_o = SBOX_FLAT[{~a_i, 3'b000} +: 8];

endmodule

// File: rtl/sbox_sched_word.sv
// sbox_word: SBOX_LANES S-box lanes mapping one 32-bit word, purely combinational.
module sbox_word
  import sbox_sched_pkg::*;
(
  input  logic [31:0] w_i,
  output logic [31:0] w_o
);

  for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
    sbox u_sbox (
      .a_i (lane_byte(w_i, g)),
      .y_o (w_o[31-BYTE_W*g -: BYTE_W])
    );
  end

endmodule

// File: rtl/sbox_sched.sv
// Shares one sbox_word between the round datapath (4 beats) and key schedule (1 beat).
// Define SBOX_SCHED_RR_EN for round-robin arbitration; default is key-over-state priority.
module sbox_sched
  import sbox_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic         st_ack,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         ks_req,
  input  logic [31:0]  ks_in,
  output logic         ks_ack,
  output logic         ks_done,
  output logic [31:0]  ks_out,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic [127:0] in_q, in_d, st_out_q, st_out_d;
  logic [31:0]  kw_q, kw_d, ks_out_q, ks_out_d;
  logic [31:0]  lane_in, lane_out;
  logic         st_done_q, st_done_d, ks_done_q, ks_done_d;
  logic         st_ack_c, ks_ack_c, grant_st, grant_ks;

`ifdef SBOX_SCHED_RR_EN
  logic last_st_q, last_st_d;
  // on a tie, key wins only if state was granted last
  assign grant_ks = ks_req & (~st_req | last_st_q);

  always_comb begin
    last_st_d = last_st_q;
    if (ks_ack_c)      last_st_d = 1'b0;
    else if (st_ack_c) last_st_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_st_q <= 1'b1;
    else     last_st_q <= last_st_d;
  end
`else
  assign grant_ks = ks_req;
`endif
  assign grant_st = st_req & ~grant_ks;

  always_comb begin
    lane_in = kw_q;
    if (state_q == ST_RUN) begin
      for (int b = 0; b < ST_BEATS; b++)
        if (beat_q == b[1:0]) lane_in = in_q[127-32*b -: 32];
    end
  end

  sbox_word u_word (
    .w_i (lane_in),
    .w_o (lane_out)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    in_d      = in_q;
    kw_d      = kw_q;
    st_out_d  = st_out_q;
    ks_out_d  = ks_out_q;
    st_done_d = 1'b0;
    ks_done_d = 1'b0;
    st_ack_c  = 1'b0;
    ks_ack_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_ks) begin
          kw_d     = ks_in;
          ks_ack_c = 1'b1;
          state_d  = KS_RUN;
        end else if (grant_st) begin
          in_d     = st_in;
          st_ack_c = 1'b1;
          beat_d   = 2'd0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int b = 0; b < ST_BEATS; b++)
          if (beat_q == b[1:0]) st_out_d[127-32*b -: 32] = lane_out;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'(ST_BEATS - 1)) begin
          state_d   = IDLE;
          st_done_d = 1'b1;
        end
      end
      KS_RUN: begin
        ks_out_d  = lane_out;
        ks_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= 2'd0;
      in_q      <= '0;
      kw_q      <= '0;
      st_out_q  <= '0;
      ks_out_q  <= '0;
      st_done_q <= 1'b0;
      ks_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      in_q      <= in_d;
      kw_q      <= kw_d;
      st_out_q  <= st_out_d;
      ks_out_q  <= ks_out_d;
      st_done_q <= st_done_d;
      ks_done_q <= ks_done_d;
    end
  end

  // acks are combinational from IDLE; keep them quiet while reset is held
  assign st_ack  = st_ack_c & ~rst;
  assign ks_ack  = ks_ack_c & ~rst;
  assign st_done = st_done_q;
  assign ks_done = ks_done_q;
  assign st_out  = st_out_q;
  assign ks_out  = ks_out_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_sched.sv
// Scoreboard bench for sbox_sched: drivers push expected results, a monitor checks done pulses.
module tb_sbox_sched;

  logic         clk = 1'b0, rst = 1'b1;
  logic         st_req = 1'b0, ks_req = 1'b0;
  logic [127:0] st_in = '0;
  logic [31:0]  ks_in = '0;
  logic         st_ack, st_done, ks_ack, ks_done, busy;
  logic [127:0] st_out;
  logic [31:0]  ks_out;

  int total = 0, bad = 0, cyc = 0;
  logic [127:0] st_exp[$];
  int           st_t[$];
  logic [31:0]  ks_exp[$];
  int           ks_t[$];

  localparam logic [127:0] V_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] ZERO_OUT = {16{8'h63}};
  localparam logic [127:0] FF_OUT   = {16{8'h16}};

  sbox_sched dut (
    .clk(clk), .rst(rst),
    .st_req(st_req), .st_in(st_in), .st_ack(st_ack), .st_done(st_done), .st_out(st_out),
    .ks_req(ks_req), .ks_in(ks_in), .ks_ack(ks_ack), .ks_done(ks_done), .ks_out(ks_out),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic st_txn(input logic [127:0] d, input logic [127:0] e, output int t);
    int n = 0;
    st_req = 1'b1;
    st_in  = d;
    do begin @(negedge clk); n++; end while (!st_ack && n < 60);
    total++;
    t = cyc;
    if (!st_ack) begin
      bad++;
      $display("FAIL st_ack_timeout: got no ack want ack within 60 cycles");
    end else begin
      st_exp.push_back(e);
      st_t.push_back(cyc);
    end
    @(posedge clk); #1;
    st_req = 1'b0;
  endtask

  task automatic ks_txn(input logic [31:0] d, input logic [31:0] e, output int t);
    int n = 0;
    ks_req = 1'b1;
    ks_in  = d;
    do begin @(negedge clk); n++; end while (!ks_ack && n < 60);
    total++;
    t = cyc;
    if (!ks_ack) begin
      bad++;
      $display("FAIL ks_ack_timeout: got no ack want ack within 60 cycles");
    end else begin
      ks_exp.push_back(e);
      ks_t.push_back(cyc);
    end
    @(posedge clk); #1;
    ks_req = 1'b0;
  endtask

  // monitor: compare every done pulse against the scoreboard
  initial begin
    logic pr_st = 1'b0, pa_st = 1'b0, pr_ks = 1'b0, pa_ks = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pr_st = 1'b0; pr_ks = 1'b0;
      end else begin
        assert (!(pr_st && !pa_st && !st_req)) else $error("st_req dropped before st_ack");
        assert (!(pr_ks && !pa_ks && !ks_req)) else $error("ks_req dropped before ks_ack");
        pr_st = st_req; pa_st = st_ack; pr_ks = ks_req; pa_ks = ks_ack;
        if (st_done) begin
          chk("st_done_busy", busy, 0);
          if (st_exp.size() == 0) chk("st_done_unexpected", 1, 0);
          else begin
            chk("st_out", st_out, st_exp.pop_front());
            chk("st_latency", cyc - st_t.pop_front(), 5);
          end
        end
        if (ks_done) begin
          chk("ks_done_busy", busy, 0);
          if (ks_exp.size() == 0) chk("ks_done_unexpected", 1, 0);
          else begin
            chk("ks_out", ks_out, ks_exp.pop_front());
            chk("ks_latency", cyc - ks_t.pop_front(), 2);
          end
        end
      end
    end
  end

  initial begin
    int ts, tk, tk2, t1, t2, t3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_st_out", st_out, 0);
    chk("rst_ks_out", ks_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", {st_done, ks_done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic state op, busy for exactly the four beats
    @(posedge clk); #1;
    st_txn(V_IN, V_OUT, ts);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_run", busy, 1);
    end
    @(negedge clk);
    chk("busy_done_cycle", busy, 0);

    // tie after a state grant: key first, state acked at ks_done cycle
    @(posedge clk); #1;
    fork
      st_txn(V_IN, V_OUT, ts);
      ks_txn(32'h09cf4f3c, 32'h018a84eb, tk);
    join
    chk("tie_state_after_key", ts, tk + 2);
    repeat (6) @(posedge clk); #1;

    // key requested twice while state waits
    fork
      st_txn({16{8'hff}}, FF_OUT, ts);
      begin
        ks_txn(32'h11223344, 32'h8293c31b, tk);
        ks_txn(32'h00000000, 32'h63636363, tk2);
      end
    join
`ifdef SBOX_SCHED_RR_EN
    chk("rr_state_second", ts, tk + 2);
    chk("rr_key_third", tk2, tk + 7);
`else
    chk("fp_key_second", tk2, tk + 2);
    chk("fp_state_third", ts, tk + 4);
`endif
    repeat (8) @(posedge clk); #1;

    // key request during beat 1 waits for the st_done cycle
    fork
      st_txn(V_IN, V_OUT, ts);
      begin
        @(posedge clk); @(posedge clk); #1;
        ks_txn(32'hffffffff, 32'h16161616, tk);
      end
    join
    chk("ks_wait_for_done", tk, ts + 5);
    repeat (4) @(posedge clk); #1;

    // reset at T+2 aborts the state operation
    st_txn('0, ZERO_OUT, ts);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_st_out", st_out, 0);
    chk("abort_ks_out", ks_out, 0);
    chk("abort_flags", {st_ack, ks_ack, st_done, ks_done, busy}, 0);
    st_exp.delete(); st_t.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", st_done, 0);
    end
    @(posedge clk); #1;
    st_txn('0, ZERO_OUT, ts);
    repeat (6) @(posedge clk); #1;

    // continuous all-FF state requests: one block per 5 cycles
    st_txn({16{8'hff}}, FF_OUT, t1);
    st_txn({16{8'hff}}, FF_OUT, t2);
    st_txn({16{8'hff}}, FF_OUT, t3);
    chk("st_tput_1", t2 - t1, 5);
    chk("st_tput_2", t3 - t2, 5);

    repeat (10) @(negedge clk);
    chk("st_queue_drained", st_exp.size(), 0);
    chk("ks_queue_drained", ks_exp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
